rgals_ratio_scheduler: RTL

- Schedules the RGALS transfer windows for the suppressor datapath. Runs on the base clock and generates aligned left/right divided-clock tick enables with programmable divide ratios.
- Asserts a window strobe on every cycle where both divided domains are phase-aligned, which is the only cycle data may cross.
- Accepts ratio reconfiguration through a valid/ready handshake and applies new ratios only at a hyperperiod boundary, so the two divided domains never lose alignment.

---
 rtl/rgals_ratio_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rgals_ratio_scheduler.sv
// rtl/rgals_ratio_scheduler.sv - RGALS left/right divided-clock tick scheduler
// Ratio changes land only on a hyperperiod boundary so both domains stay phase-aligned.
module rgals_ratio_scheduler #(
  parameter int p_div_width         = 4,
  parameter int p_default_left_div  = 3,
  parameter int p_default_right_div = 5
) (
  input  logic                   clk,
  input  logic                   clk_reset_n,
  input  logic                   en,
  input  logic                   cfg_val,
  output logic                   cfg_rdy,
  input  logic [p_div_width-1:0] cfg_left_div,
  input  logic [p_div_width-1:0] cfg_right_div,
  output logic                   cfg_err,
  output logic                   tick_left,
  output logic                   tick_right,
  output logic                   window,
  output logic [p_div_width-1:0] phase_left,
  output logic [p_div_width-1:0] phase_right,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_run   = 2'd1,
    st_drain = 2'd2
  } state_t;

  localparam logic [p_div_width-1:0] one   = p_div_width'(1);
  localparam logic [p_div_width-1:0] def_l = p_div_width'(p_default_left_div);
  localparam logic [p_div_width-1:0] def_r = p_div_width'(p_default_right_div);

  state_t                 st_q, st_d;
  logic [p_div_width-1:0] div_l_q, div_l_d, div_r_q, div_r_d;
  logic [p_div_width-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [p_div_width-1:0] cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic                   err_q, err_d;

  logic                   at_end_l, at_end_r, boundary, accept, legal, take;
  logic [p_div_width-1:0] cnt_l_inc, cnt_r_inc;

  assign at_end_l  = (cnt_l_q == div_l_q - one);
  assign at_end_r  = (cnt_r_q == div_r_q - one);
  assign boundary  = (st_q != st_idle) && at_end_l && at_end_r;
  assign accept    = cfg_val && cfg_rdy;
  assign legal     = (|cfg_left_div) && (|cfg_right_div);
  assign take      = accept && legal;
  // Each counter wraps on its own; at the boundary both land on 0 together.
  assign cnt_l_inc = at_end_l ? '0 : cnt_l_q + one;
  assign cnt_r_inc = at_end_r ? '0 : cnt_r_q + one;

  always_ff @(posedge clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      st_q       <= st_idle;
      div_l_q    <= def_l;
      div_r_q    <= def_r;
      pend_l_q   <= '0;
      pend_r_q   <= '0;
      pend_vld_q <= 1'b0;
      cnt_l_q    <= '0;
      cnt_r_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      div_l_q    <= div_l_d;
      div_r_q    <= div_r_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      pend_vld_q <= pend_vld_d;
      cnt_l_q    <= cnt_l_d;
      cnt_r_q    <= cnt_r_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    div_l_d    = div_l_q;
    div_r_d    = div_r_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    pend_vld_d = pend_vld_q;
    cnt_l_d    = cnt_l_q;
    cnt_r_d    = cnt_r_q;
    err_d      = accept && !legal;
    case (st_q)
      st_idle: begin
        cnt_l_d = '0;
        cnt_r_d = '0;
        if (take) begin
          div_l_d = cfg_left_div;
          div_r_d = cfg_right_div;
        end
        if (en) st_d = st_run;
      end
      st_run: begin
        cnt_l_d = cnt_l_inc;
        cnt_r_d = cnt_r_inc;
        if (boundary) begin
          st_d = en ? st_run : st_idle;
          if (take) begin
            div_l_d = cfg_left_div;
            div_r_d = cfg_right_div;
          end
        end else if (take) begin
          pend_l_d   = cfg_left_div;
          pend_r_d   = cfg_right_div;
          pend_vld_d = 1'b1;
          st_d       = st_drain;
        end
      end
      st_drain: begin
        cnt_l_d = cnt_l_inc;
        cnt_r_d = cnt_r_inc;
        if (boundary) begin
          if (pend_vld_q) begin
            div_l_d = pend_l_q;
            div_r_d = pend_r_q;
          end
          pend_vld_d = 1'b0;
          st_d       = en ? st_run : st_idle;
        end
      end
      default: st_d = st_idle;
    endcase
  end

  always_comb begin
    tick_left   = (st_q != st_idle) && (cnt_l_q == '0);
    tick_right  = (st_q != st_idle) && (cnt_r_q == '0);
    window      = tick_left && tick_right;
    phase_left  = cnt_l_q;
    phase_right = cnt_r_q;
    cfg_rdy     = (st_q != st_drain);
    cfg_err     = err_q;
    state       = st_q;
  end

endmodule
